mult: RTL and testbench
=======================

MULT -- requirements
Module: mult

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port MControl, input, 1 bit: start pulse; loads operands and begins a multiply.
REQ-004 SHALL have port A, input, 32 bits: multiplicand, signed two's complement.
REQ-005 SHALL have port B, input, 32 bits: multiplier, signed two's complement.
REQ-006 SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when a new product is valid.
REQ-008 SHALL have port resultHi, output, 32 bits: upper 32 bits of the 64-bit signed product.
REQ-009 SHALL have port resultLo, output, 32 bits: lower 32 bits of the 64-bit signed product.

Function
REQ-010 SHALL compute the full 64-bit signed product A*B using radix-2 Booth recoding, one iteration per clock.
REQ-011 SHALL implement three states: IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with MControl=1 at edge 0, latch A and B, set iteration count to 0, set the accumulator {P[32:0], Q[31:0], q-1} to {33'd0, B, 1'b0}, and enter RUN.
REQ-013 SHALL, in RUN, inspect {Q[0], q-1} each cycle: 01 -> P += sext33(A); 10 -> P -= sext33(A); 00/11 -> no add.
REQ-014 SHALL, after the add, arithmetically shift the whole 66-bit accumulator right by 1 in the same cycle.
REQ-015 SHALL use a 33-bit P path so that A=0x80000000 never overflows.
REQ-016 SHALL, after exactly 32 RUN cycles (edges 1..32), enter DONE at edge 33.
REQ-017 SHALL, on entering DONE, load resultHi=P[31:0] and resultLo=Q and assert done for that one cycle, then return to IDLE on the next edge.
REQ-018 SHALL deliver the result with a fixed latency of 33 cycles from the start edge to results valid with done=1, independent of operand values, with no early exit.
REQ-019 SHALL hold busy=1 in RUN only, and busy=0 in IDLE and in DONE.
REQ-020 SHALL hold resultHi/resultLo stable between done pulses; starting a new multiply SHALL NOT clear them.
REQ-021 SHALL, if MControl=1 while in RUN, abandon the current operation, reload the new operands as in IDLE, restart the count, and suppress done for the abandoned operation.
REQ-022 SHALL, if MControl=1 in DONE, still pulse done for the finished product and start the new operation in the same edge, going to RUN rather than IDLE.
REQ-023 SHALL treat operands that change while not loading as don't-care; only the values latched at the start edge are used.
REQ-024 SHALL raise no overflow flag; the 64-bit product is always exact.

Reset
REQ-025 SHALL, when reset=0 at a rising edge, force state=IDLE, busy=0, done=0, resultHi=0, resultLo=0 and clear the accumulator and count.
REQ-026 SHALL give reset priority over MControl; MControl is ignored on any edge where reset=0.
REQ-027 SHALL, on reset mid-RUN, abort the operation with no done pulse and no update of results beyond zeroing.
REQ-028 SHALL require reset to be asserted for at least one edge after power-up; outputs before that are undefined.

Verification
REQ-029 SHALL be verified with A=3, B=5, start at edge 0 -> busy 1..32, done=1 at edge 33, resultHi=0x00000000, resultLo=0x0000000F.
REQ-030 SHALL be verified with A=0xFFFFFFFF (-1), B=0x00000001 -> resultHi=0xFFFFFFFF, resultLo=0xFFFFFFFF.
REQ-031 SHALL be verified with A=B=0x80000000 -> resultHi=0x40000000, resultLo=0x00000000; and A=B=0x7FFFFFFF -> resultHi=0x3FFFFFFF, resultLo=0x00000001.
REQ-032 SHALL be verified with A=0x80000000, B=0x7FFFFFFF -> resultHi=0xC0000000, resultLo=0x80000000.
REQ-033 SHALL be verified with start A=7, B=9, then reset=0 at edge 10 -> no done pulse, results=0; then start 2*2 -> results 0/4 after 33 cycles.
REQ-034 SHALL be verified with start A=7, B=9, then MControl with A=-3, B=4 at edge 5 -> single done at edge 38, resultHi=0xFFFFFFFF, resultLo=0xFFFFFFF4, and prior results held until then.

Source files
------------

// File: rtl/mult.sv
// Signed 32x32 -> 64 radix-2 Booth multiplier, one iteration per clock, fixed 33-cycle latency.
// No backpressure: done is a single-cycle pulse and a new start at any time restarts the operation.
module mult (
    input  logic        clk,
    input  logic        reset,
    input  logic        MControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] resultHi,
    output logic [31:0] resultLo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_a;
    logic [32:0] r_p;
    logic [31:0] r_q;
    logic        r_qm1;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_iter;
    logic        w_finish;
    logic        w_last;
    logic [32:0] w_a33;
    logic [32:0] w_psum;

    assign w_last = (r_cnt == 6'd32);
    // 33-bit P keeps P - (-2^31) representable.
    assign w_a33  = {r_a[31], r_a};

    always_comb begin
        w_state_next = r_state;
        w_iter       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MControl) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (MControl) begin
                    w_state_next = S_RUN;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                    w_finish     = 1'b1;
                end else begin
                    w_iter = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = MControl ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_psum = r_p;
        case ({r_q[0], r_qm1})
            2'b01:   w_psum = r_p + w_a33;
            2'b10:   w_psum = r_p - w_a33;
            default: w_psum = r_p;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_a     <= 32'd0;
            r_p     <= 33'd0;
            r_q     <= 32'd0;
            r_qm1   <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (MControl) begin
                r_a   <= A;
                r_cnt <= 6'd0;
                r_p   <= 33'd0;
                r_q   <= B;
                r_qm1 <= 1'b0;
            end else if (w_iter) begin
                // Add/subtract then arithmetic shift of {P,Q,q-1} in one step.
                r_p   <= {w_psum[32], w_psum[32:1]};
                r_q   <= {w_psum[0], r_q[31:1]};
                r_qm1 <= r_q[0];
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_finish) begin
                r_hi <= r_p[31:0];
                r_lo <= r_q;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign resultHi = r_hi;
    assign resultLo = r_lo;

endmodule

// File: tb/tb_mult.sv
// Directed bench for the Booth multiplier: latency, corner products, abort and reset behaviour.
module tb_mult;

    logic        clk;
    logic        reset;
    logic        MControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] resultHi;
    logic [31:0] resultLo;

    int total = 0;
    int bad   = 0;

    mult dut (
        .clk      (clk),
        .reset    (reset),
        .MControl (MControl),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .resultHi (resultHi),
        .resultLo (resultLo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start at edge 0, then verify busy/done timing and the product at edge 33.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int early;
        A = a; B = b; MControl = 1'b1;
        tick();
        MControl = 1'b0;
        A = 32'hDEADBEEF; B = 32'h12345678;
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        early = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b1) early++;
        end
        chk({tag, "_run_window"}, 32'(early), 32'd0);
        tick();
        chk({tag, "_done_e33"}, 32'(done), 32'd1);
        chk({tag, "_busy_e33"}, 32'(busy), 32'd0);
        chk({tag, "_hi"}, resultHi, ehi);
        chk({tag, "_lo"}, resultLo, elo);
        tick();
        chk({tag, "_done_e34"}, 32'(done), 32'd0);
        chk({tag, "_hi_held"}, resultHi, ehi);
        chk({tag, "_lo_held"}, resultLo, elo);
    endtask

    initial begin
        int cnt_err;
        reset = 1'b0; MControl = 1'b0; A = 32'd0; B = 32'd0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", resultHi, 32'd0);
        chk("rst_lo", resultLo, 32'd0);
        reset = 1'b1;
        tick();

        run_mul("m3x5", 32'd3, 32'd5, 32'h00000000, 32'h0000000F);
        run_mul("mneg1x1", 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_mul("mminsq", 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_mul("mmaxsq", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
        run_mul("mminxmax", 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000);
        run_mul("m0x5", 32'd0, 32'hFFFFFFFB, 32'h00000000, 32'h00000000);

        // Restart issued while in DONE: done still pulses, then new op 6*7.
        A = 32'd3; B = 32'd5; MControl = 1'b1;
        tick();
        MControl = 1'b0;
        repeat (33) tick();
        chk("dr_done", 32'(done), 32'd1);
        chk("dr_lo", resultLo, 32'd15);
        A = 32'd6; B = 32'd7; MControl = 1'b1;
        tick();
        MControl = 1'b0;
        chk("dr_busy", 32'(busy), 32'd1);
        chk("dr_done_gone", 32'(done), 32'd0);
        chk("dr_lo_held", resultLo, 32'd15);
        repeat (32) tick();
        chk("dr_done2_early", 32'(done), 32'd0);
        tick();
        chk("dr_done2", 32'(done), 32'd1);
        chk("dr_hi2", resultHi, 32'd0);
        chk("dr_lo2", resultLo, 32'd42);
        tick();

        // Reset at edge 10 of a 7*9 operation.
        A = 32'd7; B = 32'd9; MControl = 1'b1;
        tick();
        MControl = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_hi", resultHi, 32'd0);
        chk("mr_lo", resultLo, 32'd0);
        cnt_err = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) cnt_err++;
        end
        chk("mr_no_done", 32'(cnt_err), 32'd0);
        run_mul("m2x2", 32'd2, 32'd2, 32'h00000000, 32'h00000004);

        // Restart at edge 5 abandons 7*9; only -3*4 completes, at edge 38.
        A = 32'd7; B = 32'd9; MControl = 1'b1;
        tick();
        MControl = 1'b0;
        repeat (4) tick();
        A = 32'hFFFFFFFD; B = 32'd4; MControl = 1'b1;
        tick();
        MControl = 1'b0;
        cnt_err = 0;
        for (int i = 6; i <= 37; i++) begin
            tick();
            if (done !== 1'b0 || resultHi !== 32'd0 || resultLo !== 32'd4) cnt_err++;
        end
        chk("ab_window", 32'(cnt_err), 32'd0);
        tick();
        chk("ab_done", 32'(done), 32'd1);
        chk("ab_hi", resultHi, 32'hFFFFFFFF);
        chk("ab_lo", resultLo, 32'hFFFFFFF4);
        tick();
        chk("ab_done_once", 32'(done), 32'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b0; MControl = 1'b1; A = 32'd5; B = 32'd5;
        tick();
        chk("rp_busy", 32'(busy), 32'd0);
        chk("rp_lo", resultLo, 32'd0);
        reset = 1'b1; MControl = 1'b0;
        tick();
        chk("rp_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
